// File: rtl/imem_arbiter.sv
// Arbiter that shares one memory read port between instruction fetch (F) and the LSU (L).
// Grants one transaction at a time, routes each response to its owner, and drops stale fetches.
module imem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fetch_en,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  input  logic                  i_fetch_flush,
  output logic                  o_fetch_gnt,
  output logic [DATA_WIDTH-1:0] o_fetch_data,
  output logic                  o_fetch_data_valid,
  input  logic                  i_lsu_en,
  input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
  output logic                  o_lsu_gnt,
  output logic [DATA_WIDTH-1:0] o_lsu_data,
  output logic                  o_lsu_data_valid,
  output logic                  o_mem_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_data_valid
);

  // state  | meaning
  // IDLE   | no transaction outstanding, arbitration open
  // BUSY_F | fetch transaction outstanding, waiting for response
  // BUSY_L | LSU transaction outstanding, waiting for response
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_L = 2'd2
  } state_t;

  state_t state;
  logic   squash;
  logic   last_gnt_l;

  logic fetch_req;
  logic pick_f;
  logic pick_l;

  assign fetch_req = i_fetch_en & ~i_fetch_flush;

  // Round-robin on a tie: the port that did not win last time goes first.
  assign pick_f = (state == IDLE) & fetch_req & (~i_lsu_en | last_gnt_l);
  assign pick_l = (state == IDLE) & i_lsu_en & (~fetch_req | ~last_gnt_l);

  assign o_fetch_gnt = pick_f;
  assign o_lsu_gnt   = pick_l;
  assign o_mem_en    = pick_f | pick_l;

  always_comb begin
    o_mem_addr = '0;
    if (pick_f) begin
      o_mem_addr = i_fetch_addr;
    end else if (pick_l) begin
      o_mem_addr = i_lsu_addr;
    end
  end

  // A flush in the response cycle itself squashes just as a registered flush does.
  assign o_fetch_data_valid = (state == BUSY_F) & i_mem_data_valid & ~squash & ~i_fetch_flush;
  assign o_lsu_data_valid   = (state == BUSY_L) & i_mem_data_valid;

  assign o_fetch_data = o_fetch_data_valid ? i_mem_data : '0;
  assign o_lsu_data   = o_lsu_data_valid   ? i_mem_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      squash     <= 1'b0;
      last_gnt_l <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          squash <= 1'b0;
          if (pick_f) begin
            state      <= BUSY_F;
            last_gnt_l <= 1'b0;
          end else if (pick_l) begin
            state      <= BUSY_L;
            last_gnt_l <= 1'b1;
          end
        end
        BUSY_F: begin
          if (i_mem_data_valid) begin
            state  <= IDLE;
            squash <= 1'b0;
          end else if (i_fetch_flush) begin
            squash <= 1'b1;
          end
        end
        BUSY_L: begin
          if (i_mem_data_valid) begin
            state  <= IDLE;
            squash <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          squash <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: expected grants and responses are queued when driven
// and checked by a negedge monitor; directed checks cover squash and reset corner cases.
module tb_imem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic          i_fetch_en;
  logic [AW-1:0] i_fetch_addr;
  logic          i_fetch_flush;
  logic          o_fetch_gnt;
  logic [DW-1:0] o_fetch_data;
  logic          o_fetch_data_valid;
  logic          i_lsu_en;
  logic [AW-1:0] i_lsu_addr;
  logic          o_lsu_gnt;
  logic [DW-1:0] o_lsu_data;
  logic          o_lsu_data_valid;
  logic          o_mem_en;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] i_mem_data;
  logic          i_mem_data_valid;

  imem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_fetch_en        (i_fetch_en),
    .i_fetch_addr      (i_fetch_addr),
    .i_fetch_flush     (i_fetch_flush),
    .o_fetch_gnt       (o_fetch_gnt),
    .o_fetch_data      (o_fetch_data),
    .o_fetch_data_valid(o_fetch_data_valid),
    .i_lsu_en          (i_lsu_en),
    .i_lsu_addr        (i_lsu_addr),
    .o_lsu_gnt         (o_lsu_gnt),
    .o_lsu_data        (o_lsu_data),
    .o_lsu_data_valid  (o_lsu_data_valid),
    .o_mem_en          (o_mem_en),
    .o_mem_addr        (o_mem_addr),
    .i_mem_data        (i_mem_data),
    .i_mem_data_valid  (i_mem_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          is_l;
    logic [AW-1:0] addr;
  } gnt_t;

  gnt_t          gq[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] lq[$];

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_gnt(input logic is_l, input logic [AW-1:0] addr);
    gnt_t g;
    g.is_l = is_l;
    g.addr = addr;
    gq.push_back(g);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    gnt_t g;
    logic [DW-1:0] d;
    if (o_mem_en || o_fetch_gnt || o_lsu_gnt) begin
      if (gq.size() == 0) begin
        chk("gnt_unexpected", 64'({o_mem_en, o_fetch_gnt, o_lsu_gnt}), 64'd0);
      end else begin
        g = gq.pop_front();
        chk("mem_en", 64'(o_mem_en), 64'd1);
        chk("mem_addr", 64'(o_mem_addr), 64'(g.addr));
        chk("fetch_gnt", 64'(o_fetch_gnt), 64'(!g.is_l));
        chk("lsu_gnt", 64'(o_lsu_gnt), 64'(g.is_l));
      end
    end
    if (o_fetch_data_valid) begin
      if (fq.size() == 0) begin
        chk("fetch_valid_unexpected", 64'(o_fetch_data_valid), 64'd0);
      end else begin
        d = fq.pop_front();
        chk("fetch_data", 64'(o_fetch_data), 64'(d));
      end
    end else begin
      chk("fetch_data_zero", 64'(o_fetch_data), 64'd0);
    end
    if (o_lsu_data_valid) begin
      if (lq.size() == 0) begin
        chk("lsu_valid_unexpected", 64'(o_lsu_data_valid), 64'd0);
      end else begin
        d = lq.pop_front();
        chk("lsu_data", 64'(o_lsu_data), 64'(d));
      end
    end else begin
      chk("lsu_data_zero", 64'(o_lsu_data), 64'd0);
    end
  end

  initial begin
    rst = 1'b1;
    i_fetch_en = 1'b0;
    i_fetch_addr = '0;
    i_fetch_flush = 1'b0;
    i_lsu_en = 1'b0;
    i_lsu_addr = '0;
    i_mem_data = '0;
    i_mem_data_valid = 1'b0;
    tick();
    tick();
    chk("rst_outputs", 64'({o_fetch_gnt, o_lsu_gnt, o_mem_en, o_fetch_data_valid, o_lsu_data_valid}), 64'd0);
    chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    rst = 1'b0;
    tick();

    // Single fetch, latency 2.
    i_fetch_en = 1'b1;
    i_fetch_addr = 32'h100;
    push_gnt(1'b0, 32'h100);
    tick();
    i_fetch_en = 1'b0;
    tick();
    i_mem_data = 32'hDEADBEEF;
    i_mem_data_valid = 1'b1;
    fq.push_back(32'hDEADBEEF);
    #1;
    chk("single_fetch_valid", 64'(o_fetch_data_valid), 64'd1);
    tick();
    i_mem_data_valid = 1'b0;
    i_mem_data = '0;
    chk("idle_no_req_addr", 64'(o_mem_addr), 64'd0);
    tick();

    // Tie after reset, latency 1: F, L, F, L.
    do_reset();
    i_fetch_en = 1'b1;
    i_fetch_addr = 32'h200;
    i_lsu_en = 1'b1;
    i_lsu_addr = 32'h8000;
    for (int i = 0; i < 4; i++) begin
      push_gnt(1'(i % 2), (i % 2 == 1) ? 32'h8000 : 32'h200);
      tick();
      if (i == 3) begin
        i_fetch_en = 1'b0;
        i_lsu_en = 1'b0;
      end
      i_mem_data = 32'hA000 + 32'(i);
      i_mem_data_valid = 1'b1;
      if (i % 2 == 1) lq.push_back(32'hA000 + 32'(i));
      else fq.push_back(32'hA000 + 32'(i));
      #1;
      chk("tie_busy_no_mem_en", 64'(o_mem_en), 64'd0);
      tick();
      i_mem_data_valid = 1'b0;
    end
    tick();

    // Redirect squash, latency 3.
    i_fetch_en = 1'b1;
    i_fetch_addr = 32'h300;
    push_gnt(1'b0, 32'h300);
    tick();
    i_fetch_en = 1'b0;
    i_fetch_flush = 1'b1;
    tick();
    i_fetch_flush = 1'b0;
    tick();
    i_mem_data = 32'h5555AAAA;
    i_mem_data_valid = 1'b1;
    #1;
    chk("squash_valid", 64'(o_fetch_data_valid), 64'd0);
    tick();
    i_mem_data_valid = 1'b0;
    i_fetch_en = 1'b1;
    i_fetch_addr = 32'h400;
    push_gnt(1'b0, 32'h400);
    #1;
    chk("after_squash_gnt", 64'(o_fetch_gnt), 64'd1);
    tick();
    i_fetch_en = 1'b0;
    i_mem_data = 32'h1234;
    i_mem_data_valid = 1'b1;
    fq.push_back(32'h1234);
    tick();
    i_mem_data_valid = 1'b0;

    // Flush coinciding with the response: F dropped, L unaffected.
    i_fetch_en = 1'b1;
    i_fetch_addr = 32'h500;
    push_gnt(1'b0, 32'h500);
    tick();
    i_fetch_en = 1'b0;
    i_fetch_flush = 1'b1;
    i_mem_data = 32'h600D;
    i_mem_data_valid = 1'b1;
    #1;
    chk("flush_resp_f_valid", 64'(o_fetch_data_valid), 64'd0);
    tick();
    i_fetch_flush = 1'b0;
    i_mem_data_valid = 1'b0;
    i_lsu_en = 1'b1;
    i_lsu_addr = 32'h9000;
    push_gnt(1'b1, 32'h9000);
    tick();
    i_lsu_en = 1'b0;
    i_fetch_flush = 1'b1;
    i_mem_data = 32'hC0FFEE;
    i_mem_data_valid = 1'b1;
    lq.push_back(32'hC0FFEE);
    #1;
    chk("flush_resp_l_valid", 64'(o_lsu_data_valid), 64'd1);
    tick();
    i_fetch_flush = 1'b0;
    i_mem_data_valid = 1'b0;

    // Flush in IDLE with last grant L: L still wins, no fetch grant.
    i_fetch_en = 1'b1;
    i_fetch_addr = 32'h700;
    i_fetch_flush = 1'b1;
    i_lsu_en = 1'b1;
    i_lsu_addr = 32'h9100;
    push_gnt(1'b1, 32'h9100);
    #1;
    chk("idle_flush_fetch_gnt", 64'(o_fetch_gnt), 64'd0);
    tick();
    i_fetch_en = 1'b0;
    i_fetch_flush = 1'b0;
    i_lsu_en = 1'b0;
    i_mem_data = 32'hBEEF;
    i_mem_data_valid = 1'b1;
    lq.push_back(32'hBEEF);
    tick();
    i_mem_data_valid = 1'b0;

    // Reset in BUSY_L; the late response must be ignored.
    i_lsu_en = 1'b1;
    i_lsu_addr = 32'h9200;
    push_gnt(1'b1, 32'h9200);
    tick();
    i_lsu_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", 64'({o_fetch_gnt, o_lsu_gnt, o_mem_en, o_fetch_data_valid, o_lsu_data_valid}), 64'd0);
    tick();
    rst = 1'b0;
    i_mem_data = 32'hBAD0;
    i_mem_data_valid = 1'b1;
    #1;
    chk("stale_resp_lsu_valid", 64'(o_lsu_data_valid), 64'd0);
    chk("stale_resp_fetch_valid", 64'(o_fetch_data_valid), 64'd0);
    tick();
    i_mem_data_valid = 1'b0;
    i_fetch_en = 1'b1;
    i_fetch_addr = 32'h0;
    i_lsu_en = 1'b1;
    i_lsu_addr = 32'h9300;
    push_gnt(1'b0, 32'h0);
    tick();
    i_fetch_en = 1'b0;
    i_lsu_en = 1'b0;
    i_mem_data = 32'h0F0F;
    i_mem_data_valid = 1'b1;
    fq.push_back(32'h0F0F);
    tick();
    i_mem_data_valid = 1'b0;
    tick();
    tick();

    chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
    chk("fetch_queue_drained", 64'(fq.size()), 64'd0);
    chk("lsu_queue_drained", 64'(lq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-ported instruction/data memory read port between two requesters: the fetch unit (port F) and the load/store unit (port L).
- Grants one request at a time and tracks the single outstanding transaction.
- Routes each memory response to the requester that owns it.
- Drops fetch responses that a redirect has made stale.
- Sits between the fetch stage, the LSU and the memory model/cache front end.

Parameters:
- DATA_WIDTH, `DATA_WIDTH: memory read data width.
- ADDR_WIDTH, `ADDR_WIDTH: request address width.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous reset, active-high
- i_fetch_en  input  1  fetch request; held until granted
- i_fetch_addr  input  ADDR_WIDTH  fetch PC; stable while i_fetch_en is high and ungranted
- i_fetch_flush  input  1  fetch redirect; squashes the fetch request or response
- o_fetch_gnt  output  1  fetch request accepted this cycle
- o_fetch_data  output  DATA_WIDTH  instruction word
- o_fetch_data_valid  output  1  o_fetch_data valid, one-cycle pulse
- i_lsu_en  input  1  LSU read request; held until granted
- i_lsu_addr  input  ADDR_WIDTH  LSU read address
- o_lsu_gnt  output  1  LSU request accepted this cycle
- o_lsu_data  output  DATA_WIDTH  load data
- o_lsu_data_valid  output  1  o_lsu_data valid, one-cycle pulse
- o_mem_en  output  1  memory request strobe, one cycle per transaction
- o_mem_addr  output  ADDR_WIDTH  memory request address
- i_mem_data  input  DATA_WIDTH  memory response data
- i_mem_data_valid  input  1  memory response valid; latency 1..N cycles after o_mem_en

Behaviour:
- FSM states: IDLE, BUSY_F, BUSY_L. At most one memory transaction outstanding.
- Reset (rst high, any time, including mid-transaction):
  - State goes to IDLE, squash=0, last_gnt=L, so fetch wins the first tie.
  - All valid/gnt/en outputs are 0.
  - Any response arriving after reset deasserts is ignored in IDLE.
- IDLE:
  - Effective fetch request: fr = i_fetch_en & ~i_fetch_flush.
  - If only fr is high, grant F. If only i_lsu_en is high, grant L. If both, grant the port opposite last_gnt (round-robin).
  - On a grant, in the same cycle (combinational): o_mem_en=1, o_mem_addr = winner address, and the winner's gnt=1.
  - At the clock edge: last_gnt is set to the winner and the state moves to BUSY_F or BUSY_L.
  - With no request: o_mem_en=0 and o_mem_addr=0.
  - i_mem_data_valid in IDLE is ignored (no output valid).
- BUSY_F / BUSY_L:
  - o_mem_en=0 and both gnt=0. New requests wait.
  - On i_mem_data_valid, the owner's data output = i_mem_data and its valid=1 in the same cycle (zero-latency passthrough). The state returns to IDLE and squash clears.
  - The next grant is possible the cycle after the response, so back-to-back throughput is 1 transaction per (latency+1) cycles.
  - The non-owner's data output is 0.
- Squash (BUSY_F only):
  - i_fetch_flush high in any BUSY_F cycle, including the response cycle, suppresses o_fetch_data_valid for that transaction.
  - A flush before the response sets the squash flag. A flush in the response cycle suppresses valid directly.
  - The dropped transaction still completes and returns to IDLE.
  - i_fetch_flush in BUSY_L has no effect on the LSU.
- Fairness: under continuous requests from both ports, grants alternate F, L, F, L, ...
- Data outputs are 0 whenever their valid is 0.

Test Plan:
- Single fetch: after reset, i_fetch_en=1, addr=0x100, memory latency 2 → o_fetch_gnt and o_mem_en in cycle 0 with o_mem_addr=0x100; memory returns 0xDEADBEEF in cycle 2 → o_fetch_data_valid=1 with that data in cycle 2; o_lsu_data_valid stays 0.
- Tie after reset: F at 0x200 and L at 0x8000 both held high, latency 1 → grant order F, L, F, L; o_mem_addr sequence 0x200, 0x8000, 0x200, 0x8000; one o_mem_en every 2 cycles.
- Redirect squash: fetch 0x300 granted, i_fetch_flush pulsed 1 cycle later, latency 3 → no o_fetch_data_valid; state is IDLE after the response; the next fetch at 0x400 is granted the following cycle.
- Flush in response cycle: flush coincides with i_mem_data_valid in BUSY_F → o_fetch_data_valid=0. The same flush during an L transaction → o_lsu_data_valid=1.
- Flush in IDLE: i_fetch_en=1 and i_fetch_flush=1 with i_lsu_en=1 → L granted even though last_gnt=L; no fetch grant.
- Reset mid-op: assert rst in BUSY_L; response arrives after rst deasserts → all outputs 0, no valid pulse; a fresh fetch at 0x0 is granted first.
